// File: rtl/hsi_m_tx_ctrl.sv
// HSI master command transmitter: double-buffered bytes framed onto com1/com2 as RZ dual-rail slots.
// Optional build macro HSI_M_TX_PARITY_EN appends an odd-parity bit to every byte.
module hsi_m_tx_ctrl #(
  parameter int GAP_SLOTS = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clk_en,
  input  logic [7:0] d,
  input  logic       d_wr,
  output logic       d_rdy,
  input  logic       frame_end_req,
  output logic       busy,
  output logic       tx_underrun,
  output logic       com1,
  output logic       com2
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
`ifdef HSI_M_TX_PARITY_EN
    ST_PAR   = 3'd3,
`endif
    ST_END   = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  state_t     state_r;
  logic       phase_r;
  logic [2:0] cnt_r;
  logic [3:0] gap_cnt_r;
  logic [7:0] hold_r;
  logic [7:0] shift_r;
  logic [1:0] com_r;
  logic       d_rdy_r;
  logic       busy_r;
  logic       end_pending_r;
  logic       tx_underrun_r;
  logic       wr_acc_s;
  logic       byte_done_s;

  function automatic logic [1:0] bit_code(input logic b);
    return {b, ~b};
  endfunction

  function automatic logic odd_parity(input logic [7:0] v);
    return ~(^v);
  endfunction

  assign wr_acc_s    = d_wr && d_rdy_r;
  assign d_rdy       = d_rdy_r;
  assign busy        = busy_r;
  assign tx_underrun = tx_underrun_r;
  assign com1        = com_r[1];
  assign com2        = com_r[0];

  // Flags the slot boundary at which the last symbol of a byte has finished.
  always_comb begin
`ifdef HSI_M_TX_PARITY_EN
    byte_done_s = phase_r && (state_r == ST_PAR);
`else
    byte_done_s = phase_r && (state_r == ST_DATA) && (cnt_r == 3'd0);
`endif
  end

  // Host handshake plus line FSM; phase_r=0 is the driven half of a symbol, 1 the return-to-zero half.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r       <= ST_IDLE;
      phase_r       <= 1'b0;
      cnt_r         <= 3'd0;
      gap_cnt_r     <= 4'd0;
      hold_r        <= 8'd0;
      shift_r       <= 8'd0;
      com_r         <= 2'b00;
      d_rdy_r       <= 1'b1;
      busy_r        <= 1'b0;
      end_pending_r <= 1'b0;
      tx_underrun_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        hold_r  <= d;
        d_rdy_r <= 1'b0;
        busy_r  <= 1'b1;
      end
      if (frame_end_req && (busy_r || wr_acc_s)) begin
        end_pending_r <= 1'b1;
      end
      if (clk_en) begin
        if (!phase_r && (state_r != ST_IDLE) && (state_r != ST_GAP)) begin
          com_r   <= 2'b00;
          phase_r <= 1'b1;
        end else if (byte_done_s) begin
          phase_r <= 1'b0;
          if (!d_rdy_r) begin
            state_r <= ST_DATA;
            shift_r <= hold_r;
            cnt_r   <= 3'd7;
            d_rdy_r <= 1'b1;
            com_r   <= bit_code(hold_r[7]);
          end else begin
            state_r <= ST_END;
            com_r   <= 2'b11;
            if (!end_pending_r) begin
              tx_underrun_r <= 1'b1;
            end
          end
        end else begin
          case (state_r)
            ST_IDLE: begin
              com_r <= 2'b00;
              if (!d_rdy_r) begin
                state_r       <= ST_START;
                com_r         <= 2'b11;
                phase_r       <= 1'b0;
                tx_underrun_r <= 1'b0;
              end
            end
            ST_START: begin
              state_r <= ST_DATA;
              shift_r <= hold_r;
              cnt_r   <= 3'd7;
              d_rdy_r <= 1'b1;
              com_r   <= bit_code(hold_r[7]);
              phase_r <= 1'b0;
            end
            ST_DATA: begin
              phase_r <= 1'b0;
              if (cnt_r != 3'd0) begin
                cnt_r <= cnt_r - 3'd1;
                com_r <= bit_code(shift_r[cnt_r - 3'd1]);
              end else begin
`ifdef HSI_M_TX_PARITY_EN
                state_r <= ST_PAR;
                com_r   <= bit_code(odd_parity(shift_r));
`else
                com_r   <= 2'b00;
`endif
              end
            end
            ST_END: begin
              state_r       <= ST_GAP;
              gap_cnt_r     <= 4'(GAP_SLOTS - 1);
              com_r         <= 2'b00;
              end_pending_r <= 1'b0;
            end
            ST_GAP: begin
              com_r <= 2'b00;
              if (gap_cnt_r == 4'd0) begin
                state_r <= ST_IDLE;
                busy_r  <= !d_rdy_r || wr_acc_s;
              end else begin
                gap_cnt_r <= gap_cnt_r - 4'd1;
              end
            end
            default: begin
              state_r <= ST_IDLE;
              com_r   <= 2'b00;
              phase_r <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_hsi_m_tx_ctrl.sv
// Directed bench for hsi_m_tx_ctrl: expected slot sequences are built from the line code and compared per clock.
module tb_hsi_m_tx_ctrl;

  localparam int GAP = 4;
`ifdef HSI_M_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_rst;
  logic       clk_en;
  logic [7:0] d;
  logic       d_wr;
  logic       d_rdy;
  logic       frame_end_req;
  logic       busy;
  logic       tx_underrun;
  logic       com1;
  logic       com2;

  int total_cnt = 0;
  int bad_cnt   = 0;
  int en_div    = 1;
  int div_cnt   = 0;
  logic [1:0] exp_q[$];

  hsi_m_tx_ctrl #(.GAP_SLOTS(GAP)) dut (
    .clk(clk), .n_rst(n_rst), .clk_en(clk_en), .d(d), .d_wr(d_wr), .d_rdy(d_rdy),
    .frame_end_req(frame_end_req), .busy(busy), .tx_underrun(tx_underrun),
    .com1(com1), .com2(com2)
  );

  always #5 clk = ~clk;

  // clk_en pattern: high on one clock in every en_div
  initial begin
    clk_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (div_cnt >= en_div - 1) div_cnt = 0;
      else div_cnt = div_cnt + 1;
      clk_en = (div_cnt == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_marker();
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b00);
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic p;
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back({b[i], ~b[i]});
      exp_q.push_back(2'b00);
    end
    if (PAR_EN) begin
      p = ~(^b);
      exp_q.push_back({p, ~p});
      exp_q.push_back(2'b00);
    end
  endtask

  task automatic push_gap();
    for (int i = 0; i < GAP; i++) exp_q.push_back(2'b00);
  endtask

  // Waits for the start marker, then compares each clock against the expected slot queue.
  task automatic check_frame(input string tag);
    int waited = 0;
    int n;
    while ({com1, com2} == 2'b00 && waited < 60 * en_div) begin
      tick();
      waited++;
    end
    check_val({tag, "_start"}, {30'd0, com1, com2}, 32'd3);
    n = exp_q.size() * en_div;
    for (int k = 0; k < n; k++) begin
      check_val({tag, "_line"}, {30'd0, com1, com2}, {30'd0, exp_q[k / en_div]});
      check_val({tag, "_busy"}, {31'd0, busy}, 32'd1);
      tick();
    end
    check_val({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    exp_q.delete();
  endtask

  task automatic write_byte(input logic [7:0] b, input logic with_end);
    d = b;
    d_wr = 1'b1;
    frame_end_req = with_end;
    tick();
    d_wr = 1'b0;
    frame_end_req = 1'b0;
  endtask

  task automatic pulse_end();
    frame_end_req = 1'b1;
    tick();
    frame_end_req = 1'b0;
  endtask

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (!d_rdy && n < 100) begin
      tick();
      n++;
    end
    check_val({tag, "_rdy"}, {31'd0, d_rdy}, 32'd1);
  endtask

  initial begin
    int n;
    n_rst = 1'b0;
    d = 8'd0;
    d_wr = 1'b0;
    frame_end_req = 1'b0;
    tick();
    tick();
    check_val("rst_com1", {31'd0, com1}, 32'd0);
    check_val("rst_com2", {31'd0, com2}, 32'd0);
    check_val("rst_rdy", {31'd0, d_rdy}, 32'd1);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_unr", {31'd0, tx_underrun}, 32'd0);
    n_rst = 1'b1;
    tick();
    tick();

    // 0xA5 framed with a separate end request
    push_marker(); push_byte(8'hA5); push_marker(); push_gap();
    fork
      check_frame("a5");
      begin write_byte(8'hA5, 1'b0); pulse_end(); end
    join
    check_val("a5_unr", {31'd0, tx_underrun}, 32'd0);

    if (PAR_EN) begin
      push_marker(); push_byte(8'h00); push_marker(); push_gap();
      fork
        check_frame("par00");
        write_byte(8'h00, 1'b1);
      join
    end

    // two bytes back to back, second written as soon as the holding register frees
    push_marker(); push_byte(8'h01); push_byte(8'hFF); push_marker(); push_gap();
    fork
      check_frame("b2b");
      begin
        write_byte(8'h01, 1'b0);
        wait_rdy("b2b");
        write_byte(8'hFF, 1'b1);
      end
    join
    check_val("b2b_unr", {31'd0, tx_underrun}, 32'd0);

    // no end request: frame auto-closes and flags underrun
    push_marker(); push_byte(8'h3C); push_marker(); push_gap();
    fork
      check_frame("unr");
      write_byte(8'h3C, 1'b0);
    join
    check_val("unr_set", {31'd0, tx_underrun}, 32'd1);
    tick();
    check_val("unr_sticky", {31'd0, tx_underrun}, 32'd1);
    push_marker(); push_byte(8'h5A); push_marker(); push_gap();
    fork
      check_frame("unr2");
      write_byte(8'h5A, 1'b1);
    join
    check_val("unr_clr", {31'd0, tx_underrun}, 32'd0);

    // slow slot rate: every level held for three clocks
    en_div = 3;
    tick(); tick(); tick();
    push_marker(); push_byte(8'h80); push_marker(); push_gap();
    fork
      check_frame("div3");
      write_byte(8'h80, 1'b1);
    join
    en_div = 1;
    tick(); tick();

    // asynchronous reset in the middle of a data bit
    write_byte(8'hFF, 1'b1);
    n = 0;
    while (!(com1 && !com2) && n < 100) begin
      tick();
      n++;
    end
    check_val("mid_bit1", {30'd0, com1, com2}, 32'd2);
    n_rst = 1'b0;
    #1;
    check_val("mid_com", {30'd0, com1, com2}, 32'd0);
    check_val("mid_rdy", {31'd0, d_rdy}, 32'd1);
    check_val("mid_busy", {31'd0, busy}, 32'd0);
    tick();
    n_rst = 1'b1;
    tick();
    push_marker(); push_byte(8'h69); push_marker(); push_gap();
    fork
      check_frame("post_rst");
      write_byte(8'h69, 1'b1);
    join

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
